// File: rtl/execute_stage_md.sv
// Registered MIPS execute stage: ALU, jump redirect, EX/MEM output register,
// and an iterative multiply/divide unit with HI/LO.
module execute_stage_md #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned IMM_WIDTH    = 16,
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned FUNCT_WIDTH  = 6,
  parameter int unsigned JUMP_WIDTH   = 26
) (
  input  logic                    es_i_clk,
  input  logic                    es_i_rst_n,
  input  logic                    es_i_ce,
  input  logic                    es_i_stall,
  input  logic                    es_i_flush,
  input  logic                    es_i_jr,
  input  logic                    es_i_jal,
  input  logic [JUMP_WIDTH-1:0]   es_i_jal_addr,
  input  logic [PC_WIDTH-1:0]     es_i_pc,
  input  logic                    es_i_alu_src,
  input  logic [IMM_WIDTH-1:0]    es_i_imm,
  input  logic [OPCODE_WIDTH-1:0] es_i_alu_op,
  input  logic [FUNCT_WIDTH-1:0]  es_i_alu_funct,
  input  logic [DWIDTH-1:0]       es_i_data_rs,
  input  logic [DWIDTH-1:0]       es_i_data_rt,
  output logic                    es_o_ce,
  output logic [OPCODE_WIDTH-1:0] es_o_opcode,
  output logic [DWIDTH-1:0]       es_o_alu_value,
  output logic                    es_o_change_pc,
  output logic [PC_WIDTH-1:0]     es_o_alu_pc,
  output logic                    es_o_stall,
  output logic                    es_o_md_busy
);

  localparam int unsigned CntW  = $clog2(DWIDTH);
  localparam int unsigned PcHiW = PC_WIDTH - JUMP_WIDTH - 2;
  localparam int unsigned ExtW  = DWIDTH - IMM_WIDTH;

  localparam logic [FUNCT_WIDTH-1:0] FnSllv  = FUNCT_WIDTH'(6'h04);
  localparam logic [FUNCT_WIDTH-1:0] FnSrlv  = FUNCT_WIDTH'(6'h06);
  localparam logic [FUNCT_WIDTH-1:0] FnSrav  = FUNCT_WIDTH'(6'h07);
  localparam logic [FUNCT_WIDTH-1:0] FnJr    = FUNCT_WIDTH'(6'h08);
  localparam logic [FUNCT_WIDTH-1:0] FnMfhi  = FUNCT_WIDTH'(6'h10);
  localparam logic [FUNCT_WIDTH-1:0] FnMthi  = FUNCT_WIDTH'(6'h11);
  localparam logic [FUNCT_WIDTH-1:0] FnMflo  = FUNCT_WIDTH'(6'h12);
  localparam logic [FUNCT_WIDTH-1:0] FnMtlo  = FUNCT_WIDTH'(6'h13);
  localparam logic [FUNCT_WIDTH-1:0] FnMult  = FUNCT_WIDTH'(6'h18);
  localparam logic [FUNCT_WIDTH-1:0] FnMultu = FUNCT_WIDTH'(6'h19);
  localparam logic [FUNCT_WIDTH-1:0] FnDiv   = FUNCT_WIDTH'(6'h1A);
  localparam logic [FUNCT_WIDTH-1:0] FnDivu  = FUNCT_WIDTH'(6'h1B);
  localparam logic [FUNCT_WIDTH-1:0] FnAdd   = FUNCT_WIDTH'(6'h20);
  localparam logic [FUNCT_WIDTH-1:0] FnAddu  = FUNCT_WIDTH'(6'h21);
  localparam logic [FUNCT_WIDTH-1:0] FnSub   = FUNCT_WIDTH'(6'h22);
  localparam logic [FUNCT_WIDTH-1:0] FnSubu  = FUNCT_WIDTH'(6'h23);
  localparam logic [FUNCT_WIDTH-1:0] FnAnd   = FUNCT_WIDTH'(6'h24);
  localparam logic [FUNCT_WIDTH-1:0] FnOr    = FUNCT_WIDTH'(6'h25);
  localparam logic [FUNCT_WIDTH-1:0] FnXor   = FUNCT_WIDTH'(6'h26);
  localparam logic [FUNCT_WIDTH-1:0] FnNor   = FUNCT_WIDTH'(6'h27);
  localparam logic [FUNCT_WIDTH-1:0] FnSlt   = FUNCT_WIDTH'(6'h2A);
  localparam logic [FUNCT_WIDTH-1:0] FnSltu  = FUNCT_WIDTH'(6'h2B);

  localparam logic [OPCODE_WIDTH-1:0] OpBeq   = OPCODE_WIDTH'(6'h04);
  localparam logic [OPCODE_WIDTH-1:0] OpBne   = OPCODE_WIDTH'(6'h05);
  localparam logic [OPCODE_WIDTH-1:0] OpSlti  = OPCODE_WIDTH'(6'h0A);
  localparam logic [OPCODE_WIDTH-1:0] OpSltiu = OPCODE_WIDTH'(6'h0B);
  localparam logic [OPCODE_WIDTH-1:0] OpAndi  = OPCODE_WIDTH'(6'h0C);
  localparam logic [OPCODE_WIDTH-1:0] OpOri   = OPCODE_WIDTH'(6'h0D);
  localparam logic [OPCODE_WIDTH-1:0] OpXori  = OPCODE_WIDTH'(6'h0E);
  localparam logic [OPCODE_WIDTH-1:0] OpLui   = OPCODE_WIDTH'(6'h0F);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} md_state_e;

  // State
  md_state_e                state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [DWIDTH-1:0]        mcand_q, mcand_d;  // multiplicand / divisor magnitude
  logic [DWIDTH-1:0]        acc_q, acc_d;      // product high half / partial remainder
  logic [DWIDTH-1:0]        shf_q, shf_d;      // multiplier / dividend -> quotient
  logic                     neg_res_q, neg_res_d;
  logic                     neg_rem_q, neg_rem_d;
  logic                     div0_q, div0_d;
  logic [DWIDTH-1:0]        hi_q, hi_d, lo_q, lo_d;
  logic                     ce_q, ce_d, change_pc_q, change_pc_d;
  logic [OPCODE_WIDTH-1:0]  opcode_q, opcode_d;
  logic [DWIDTH-1:0]        value_q, value_d;
  logic [PC_WIDTH-1:0]      alu_pc_q, alu_pc_d;

  // Decode
  logic is_rtype, is_mul, is_div, md_start, md_signed, is_mthi, is_mtlo, md_funct;
  logic busy, accept, logic_imm;

  assign is_rtype  = (es_i_alu_op == '0);
  assign is_mul    = is_rtype & (es_i_alu_funct == FnMult | es_i_alu_funct == FnMultu);
  assign is_div    = is_rtype & (es_i_alu_funct == FnDiv | es_i_alu_funct == FnDivu);
  assign md_start  = is_mul | is_div;
  assign md_signed = is_rtype & (es_i_alu_funct == FnMult | es_i_alu_funct == FnDiv);
  assign is_mthi   = is_rtype & (es_i_alu_funct == FnMthi);
  assign is_mtlo   = is_rtype & (es_i_alu_funct == FnMtlo);
  assign md_funct  = es_i_alu_funct inside {FnMfhi, FnMthi, FnMflo, FnMtlo,
                                            FnMult, FnMultu, FnDiv, FnDivu};
  assign logic_imm = es_i_alu_op inside {OpAndi, OpOri, OpXori};

  assign busy         = (state_q != StIdle);
  assign es_o_md_busy = busy;
  // Only HI/LO users wait on the unit; everything else flows past it.
  assign es_o_stall   = es_i_ce & busy & md_funct;
  assign accept       = es_i_ce & ~es_i_flush & ~es_i_stall & ~es_o_stall;

  // Operands
  logic [DWIDTH-1:0]   imm_sext, imm_zext, op_b, alu_result;
  logic [CntW-1:0]     shamt;
  logic [PC_WIDTH-1:0] jal_target;
  logic [DWIDTH-1:0]   jal_ret;

  assign imm_sext   = {{ExtW{es_i_imm[IMM_WIDTH-1]}}, es_i_imm};
  assign imm_zext   = {{ExtW{1'b0}}, es_i_imm};
  assign op_b       = !es_i_alu_src ? es_i_data_rt : (logic_imm ? imm_zext : imm_sext);
  assign shamt      = es_i_data_rs[CntW-1:0];
  assign jal_target = {es_i_pc[PC_WIDTH-1 -: PcHiW], es_i_jal_addr, 2'b00};
  assign jal_ret    = DWIDTH'(es_i_pc + PC_WIDTH'(8));

  // ALU result for the presented instruction
  always_comb begin
    alu_result = '0;
    if (is_rtype) begin
      case (es_i_alu_funct)
        FnSllv:        alu_result = es_i_data_rt << shamt;
        FnSrlv:        alu_result = es_i_data_rt >> shamt;
        FnSrav:        alu_result = $signed(es_i_data_rt) >>> shamt;
        FnJr:          alu_result = es_i_data_rs;
        FnMfhi:        alu_result = hi_q;
        FnMflo:        alu_result = lo_q;
        FnAdd, FnAddu: alu_result = es_i_data_rs + es_i_data_rt;
        FnSub, FnSubu: alu_result = es_i_data_rs - es_i_data_rt;
        FnAnd:         alu_result = es_i_data_rs & es_i_data_rt;
        FnOr:          alu_result = es_i_data_rs | es_i_data_rt;
        FnXor:         alu_result = es_i_data_rs ^ es_i_data_rt;
        FnNor:         alu_result = ~(es_i_data_rs | es_i_data_rt);
        FnSlt:         alu_result = DWIDTH'($signed(es_i_data_rs) < $signed(es_i_data_rt));
        FnSltu:        alu_result = DWIDTH'(es_i_data_rs < es_i_data_rt);
        default:       alu_result = '0;
      endcase
    end else begin
      case (es_i_alu_op)
        OpSlti:       alu_result = DWIDTH'($signed(es_i_data_rs) < $signed(op_b));
        OpSltiu:      alu_result = DWIDTH'(es_i_data_rs < op_b);
        OpAndi:       alu_result = es_i_data_rs & op_b;
        OpOri:        alu_result = es_i_data_rs | op_b;
        OpXori:       alu_result = es_i_data_rs ^ op_b;
        OpLui:        alu_result = imm_zext << 16;
        OpBeq, OpBne: alu_result = es_i_data_rs - op_b;
        default:      alu_result = es_i_data_rs + op_b;  // addi/addiu and address generation
      endcase
    end
  end

  // EX/MEM register next state: flush kills, stall holds, otherwise load or bubble
  always_comb begin
    ce_d        = ce_q;
    opcode_d    = opcode_q;
    value_d     = value_q;
    change_pc_d = change_pc_q;
    alu_pc_d    = alu_pc_q;
    if (es_i_flush || (!es_i_stall && !accept)) begin
      ce_d        = 1'b0;
      opcode_d    = '0;
      value_d     = '0;
      change_pc_d = 1'b0;
      alu_pc_d    = '0;
    end else if (!es_i_stall) begin
      ce_d        = 1'b1;
      opcode_d    = es_i_alu_op;
      change_pc_d = es_i_jal | es_i_jr;
      alu_pc_d    = es_i_jal ? jal_target : (es_i_jr ? PC_WIDTH'(es_i_data_rs) : '0);
      if (es_i_jal)                          value_d = jal_ret;
      else if (md_start | is_mthi | is_mtlo) value_d = '0;
      else                                   value_d = alu_result;
    end
  end

  // One mul/div iteration and the sign-corrected final results
  logic [DWIDTH:0]     mul_sum, div_shift;
  logic [DWIDTH-1:0]   mul_acc, mul_shf, div_rem, div_quo, quot_fix, rem_fix, mag_a, mag_b;
  logic [2*DWIDTH-1:0] prod, prod_fix;
  logic                div_ge, last, sign_a, sign_b;

  assign mul_sum   = {1'b0, acc_q} + {1'b0, (shf_q[0] ? mcand_q : '0)};
  assign mul_acc   = mul_sum[DWIDTH:1];
  assign mul_shf   = {mul_sum[0], shf_q[DWIDTH-1:1]};
  assign div_shift = {acc_q, shf_q[DWIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mcand_q});
  // When div_ge holds the difference is below the divisor, so it fits in DWIDTH bits.
  assign div_rem   = div_ge ? (div_shift[DWIDTH-1:0] - mcand_q) : div_shift[DWIDTH-1:0];
  assign div_quo   = {shf_q[DWIDTH-2:0], div_ge};
  assign prod      = {mul_acc, mul_shf};
  assign prod_fix  = neg_res_q ? -prod : prod;
  assign quot_fix  = div0_q ? '1 : (neg_res_q ? -div_quo : div_quo);
  assign rem_fix   = neg_rem_q ? -div_rem : div_rem;
  assign last      = (cnt_q == CntW'(DWIDTH - 1));

  // Magnitudes as unsigned values: the most-negative operand maps exactly to 2^(DWIDTH-1).
  assign sign_a = md_signed & es_i_data_rs[DWIDTH-1];
  assign sign_b = md_signed & es_i_data_rt[DWIDTH-1];
  assign mag_a  = sign_a ? -es_i_data_rs : es_i_data_rs;
  assign mag_b  = sign_b ? -es_i_data_rt : es_i_data_rt;

  // Mul/div FSM and HI/LO next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    shf_d     = shf_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      StIdle: begin
        if (accept && md_start) begin
          state_d   = is_mul ? StMul : StDiv;
          cnt_d     = '0;
          mcand_d   = mag_b;
          acc_d     = '0;
          shf_d     = mag_a;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          div0_d    = (es_i_data_rt == '0);
        end
        if (accept && is_mthi) hi_d = es_i_data_rs;
        if (accept && is_mtlo) lo_d = es_i_data_rs;
      end
      StMul: begin
        acc_d = mul_acc;
        shf_d = mul_shf;
        cnt_d = cnt_q + CntW'(1);
        if (last) begin
          hi_d    = prod_fix[2*DWIDTH-1:DWIDTH];
          lo_d    = prod_fix[DWIDTH-1:0];
          state_d = StIdle;
        end
      end
      StDiv: begin
        acc_d = div_rem;
        shf_d = div_quo;
        cnt_d = cnt_q + CntW'(1);
        if (last) begin
          hi_d    = rem_fix;
          lo_d    = quot_fix;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // An aborted operation leaves HI/LO untouched, even on its final iteration.
    if (es_i_flush && busy) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // EX/MEM output register
  always_ff @(posedge es_i_clk or negedge es_i_rst_n) begin
    if (!es_i_rst_n) begin
      ce_q        <= 1'b0;
      opcode_q    <= '0;
      value_q     <= '0;
      change_pc_q <= 1'b0;
      alu_pc_q    <= '0;
    end else begin
      ce_q        <= ce_d;
      opcode_q    <= opcode_d;
      value_q     <= value_d;
      change_pc_q <= change_pc_d;
      alu_pc_q    <= alu_pc_d;
    end
  end

  // Mul/div datapath, FSM and HI/LO registers
  always_ff @(posedge es_i_clk or negedge es_i_rst_n) begin
    if (!es_i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      shf_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      shf_q     <= shf_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign es_o_ce        = ce_q;
  assign es_o_opcode    = opcode_q;
  assign es_o_alu_value = value_q;
  assign es_o_change_pc = change_pc_q;
  assign es_o_alu_pc    = alu_pc_q;

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md.
module tb_execute_stage_md;

  logic        clk, rst_n;
  logic        ce, stall, flush, jr, jal, alu_src;
  logic [25:0] jal_addr;
  logic [31:0] pc, rs, rt;
  logic [15:0] imm;
  logic [5:0]  op, fn;
  logic        o_ce, o_change_pc, o_stall, o_busy;
  logic [5:0]  o_opcode;
  logic [31:0] o_value, o_pc;

  int vectors = 0;
  int miscompares = 0;

  execute_stage_md dut (
    .es_i_clk       (clk),
    .es_i_rst_n     (rst_n),
    .es_i_ce        (ce),
    .es_i_stall     (stall),
    .es_i_flush     (flush),
    .es_i_jr        (jr),
    .es_i_jal       (jal),
    .es_i_jal_addr  (jal_addr),
    .es_i_pc        (pc),
    .es_i_alu_src   (alu_src),
    .es_i_imm       (imm),
    .es_i_alu_op    (op),
    .es_i_alu_funct (fn),
    .es_i_data_rs   (rs),
    .es_i_data_rt   (rt),
    .es_o_ce        (o_ce),
    .es_o_opcode    (o_opcode),
    .es_o_alu_value (o_value),
    .es_o_change_pc (o_change_pc),
    .es_o_alu_pc    (o_pc),
    .es_o_stall     (o_stall),
    .es_o_md_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        src;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp;
  } alu_vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce = 0; stall = 0; flush = 0; jr = 0; jal = 0; alu_src = 0;
    jal_addr = '0; pc = '0; imm = '0; op = '0; fn = '0; rs = '0; rt = '0;
  endtask

  // Present a mul/div instruction for one accept edge, then go idle.
  task automatic md_issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic ce_seen, output logic [31:0] val_seen,
                          output logic busy_seen);
    idle();
    ce = 1; fn = f; rs = a; rt = b;
    tick();
    ce_seen = o_ce; val_seen = o_value; busy_seen = o_busy;
    idle();
  endtask

  // Present mflo until accepted (counting stalled cycles), then mfhi.
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo, output int stalls);
    int n;
    idle();
    ce = 1; fn = 6'h12;
    #1;
    n = 0;
    while (o_stall === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tick();
    lo = o_value;
    fn = 6'h10;
    tick();
    hi = o_value;
    idle();
    stalls = n;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    tick(); tick();
    vectors++; if (o_ce !== 1'b0) begin miscompares++; $display("FAIL reset_ce: got %b want 0", o_ce); end
    vectors++; if (o_value !== 32'h0) begin miscompares++; $display("FAIL reset_value: got %h want 0", o_value); end
    vectors++; if (o_change_pc !== 1'b0 || o_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %b/%h want 0/0", o_change_pc, o_pc); end
    vectors++; if (o_busy !== 1'b0 || o_stall !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b/%b want 0/0", o_busy, o_stall); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_alu();
    alu_vec_t v[9];
    v[0] = '{6'h00, 6'h20, 1'b0, 16'h0000, 32'h00000005, 32'h00000007, 32'h0000000C};
    v[1] = '{6'h00, 6'h22, 1'b0, 16'h0000, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    v[2] = '{6'h08, 6'h00, 1'b1, 16'hFFFF, 32'h0000000A, 32'h00000000, 32'h00000009};
    v[3] = '{6'h0D, 6'h00, 1'b1, 16'h8F0F, 32'h000000F0, 32'h00000000, 32'h00008FFF};
    v[4] = '{6'h00, 6'h2A, 1'b0, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    v[5] = '{6'h00, 6'h2B, 1'b0, 16'h0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    v[6] = '{6'h00, 6'h07, 1'b0, 16'h0000, 32'h00000004, 32'h80000000, 32'hF8000000};
    v[7] = '{6'h0F, 6'h00, 1'b1, 16'h1234, 32'h00000000, 32'h00000000, 32'h12340000};
    v[8] = '{6'h00, 6'h27, 1'b0, 16'h0000, 32'h0F0F0000, 32'h00F0F000, 32'hF0000FFF};
    for (int i = 0; i < 9; i++) begin
      idle();
      ce = 1; op = v[i].op; fn = v[i].fn; alu_src = v[i].src; imm = v[i].imm;
      rs = v[i].rs; rt = v[i].rt;
      tick();
      vectors++; if (o_ce !== 1'b1 || o_opcode !== v[i].op || o_value !== v[i].exp) begin
        miscompares++;
        $display("FAIL alu[%0d]: got ce=%b op=%h val=%h want ce=1 op=%h val=%h",
                 i, o_ce, o_opcode, o_value, v[i].op, v[i].exp);
      end
    end
    idle();
    tick();
    vectors++; if (o_ce !== 1'b0 || o_value !== 32'h0 || o_opcode !== 6'h0) begin miscompares++; $display("FAIL alu_bubble: got ce=%b val=%h op=%h want 0/0/0", o_ce, o_value, o_opcode); end
  endtask

  task automatic test_mult();
    logic c, b; logic [31:0] v, hi, lo; int s;
    md_issue(6'h18, 32'hFFFFFFFE, 32'h00000003, c, v, b);
    vectors++; if (c !== 1'b1 || v !== 32'h0 || b !== 1'b1) begin miscompares++; $display("FAIL mult_retire: got ce=%b val=%h busy=%b want 1/0/1", c, v, b); end
    read_hilo(hi, lo, s);
    vectors++; if (s !== 32) begin miscompares++; $display("FAIL mult_stall_cycles: got %0d want 32", s); end
    vectors++; if (lo !== 32'hFFFFFFFA) begin miscompares++; $display("FAIL mult_lo: got %h want FFFFFFFA", lo); end
    vectors++; if (hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi: got %h want FFFFFFFF", hi); end
    md_issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, c, v, b);
    read_hilo(hi, lo, s);
    vectors++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin miscompares++; $display("FAIL multu_max: got %h%h want FFFFFFFE00000001", hi, lo); end
    md_issue(6'h18, 32'h80000000, 32'h80000000, c, v, b);
    read_hilo(hi, lo, s);
    vectors++; if ({hi, lo} !== 64'h40000000_00000000) begin miscompares++; $display("FAIL mult_minneg: got %h%h want 4000000000000000", hi, lo); end
  endtask

  task automatic test_div();
    logic c, b; logic [31:0] v, hi, lo; int s;
    md_issue(6'h1A, 32'hFFFFFFF9, 32'h00000002, c, v, b);
    read_hilo(hi, lo, s);
    vectors++; if (s !== 32) begin miscompares++; $display("FAIL div_stall_cycles: got %0d want 32", s); end
    vectors++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_signed: got hi=%h lo=%h want FFFFFFFF/FFFFFFFD", hi, lo); end
    md_issue(6'h1B, 32'h12345678, 32'h00000000, c, v, b);
    read_hilo(hi, lo, s);
    vectors++; if (lo !== 32'hFFFFFFFF || hi !== 32'h12345678 || s !== 32) begin miscompares++; $display("FAIL divu_zero: got hi=%h lo=%h stalls=%0d want 12345678/FFFFFFFF/32", hi, lo, s); end
    md_issue(6'h1A, 32'hFFFFFFF9, 32'h00000000, c, v, b);
    read_hilo(hi, lo, s);
    vectors++; if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin miscompares++; $display("FAIL div_zero_signed: got hi=%h lo=%h want FFFFFFF9/FFFFFFFF", hi, lo); end
    md_issue(6'h1B, 32'd100, 32'd7, c, v, b);
    read_hilo(hi, lo, s);
    vectors++; if (lo !== 32'd14 || hi !== 32'd2) begin miscompares++; $display("FAIL divu: got hi=%h lo=%h want 2/E", hi, lo); end
  endtask

  task automatic test_flush_stall_mul();
    logic c, b; logic [31:0] v, hi, lo; int s;
    idle(); ce = 1; fn = 6'h11; rs = 32'h00000011; tick();
    idle(); ce = 1; fn = 6'h13; rs = 32'h00000022; tick();
    md_issue(6'h18, 32'd7, 32'd9, c, v, b);
    ce = 1; fn = 6'h20; rs = 32'd3; rt = 32'd4;
    #1;
    vectors++; if (o_stall !== 1'b0) begin miscompares++; $display("FAIL add_during_mul_stall: got %b want 0", o_stall); end
    tick();
    vectors++; if (o_ce !== 1'b1 || o_value !== 32'd7 || o_busy !== 1'b1) begin miscompares++; $display("FAIL add_during_mul: got ce=%b val=%h busy=%b want 1/7/1", o_ce, o_value, o_busy); end
    idle();
    tick(); tick(); tick();
    flush = 1;
    tick();
    vectors++; if (o_busy !== 1'b0 || o_ce !== 1'b0) begin miscompares++; $display("FAIL flush_mul: got busy=%b ce=%b want 0/0", o_busy, o_ce); end
    read_hilo(hi, lo, s);
    vectors++; if (hi !== 32'h11 || lo !== 32'h22 || s !== 0) begin miscompares++; $display("FAIL flush_hilo_kept: got hi=%h lo=%h stalls=%0d want 11/22/0", hi, lo, s); end
    // Flush coinciding with a mult accept must not start it.
    idle(); ce = 1; fn = 6'h18; rs = 32'd2; rt = 32'd3; flush = 1;
    tick();
    vectors++; if (o_busy !== 1'b0 || o_ce !== 1'b0) begin miscompares++; $display("FAIL flush_with_accept: got busy=%b ce=%b want 0/0", o_busy, o_ce); end
    // A running multiply keeps iterating through a downstream stall.
    md_issue(6'h19, 32'd6, 32'd7, c, v, b);
    stall = 1;
    for (int i = 0; i < 40; i++) tick();
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL mul_under_stall_busy: got %b want 0", o_busy); end
    read_hilo(hi, lo, s);
    vectors++; if (lo !== 32'd42 || hi !== 32'd0) begin miscompares++; $display("FAIL mul_under_stall: got hi=%h lo=%h want 0/2A", hi, lo); end
  endtask

  task automatic test_stall_hold();
    idle(); ce = 1; fn = 6'h20; rs = 32'd5; rt = 32'd7; tick();
    fn = 6'h22; stall = 1;
    tick(); tick();
    vectors++; if (o_ce !== 1'b1 || o_value !== 32'h0C) begin miscompares++; $display("FAIL stall_hold: got ce=%b val=%h want 1/C", o_ce, o_value); end
    stall = 0;
    tick();
    vectors++; if (o_value !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL stall_release: got %h want FFFFFFFE", o_value); end
    idle(); tick();
  endtask

  task automatic test_jump();
    idle(); tick();
    ce = 1; jal = 1; op = 6'h03; pc = 32'h00400010; jal_addr = 26'h0100000; stall = 1;
    tick();
    vectors++; if (o_change_pc !== 1'b0 || o_pc !== 32'h0) begin miscompares++; $display("FAIL jal_stall1: got %b/%h want 0/0", o_change_pc, o_pc); end
    tick();
    vectors++; if (o_change_pc !== 1'b0 || o_ce !== 1'b0) begin miscompares++; $display("FAIL jal_stall2: got %b/%b want 0/0", o_change_pc, o_ce); end
    stall = 0;
    tick();
    vectors++; if (o_change_pc !== 1'b1 || o_pc !== 32'h00400000) begin miscompares++; $display("FAIL jal_pulse: got %b/%h want 1/00400000", o_change_pc, o_pc); end
    vectors++; if (o_value !== 32'h00400018 || o_opcode !== 6'h03) begin miscompares++; $display("FAIL jal_ret: got %h op=%h want 00400018 op=03", o_value, o_opcode); end
    idle();
    tick();
    vectors++; if (o_change_pc !== 1'b0 || o_pc !== 32'h0) begin miscompares++; $display("FAIL jal_pulse_end: got %b/%h want 0/0", o_change_pc, o_pc); end
    ce = 1; jr = 1; fn = 6'h08; rs = 32'h00001234;
    tick();
    vectors++; if (o_change_pc !== 1'b1 || o_pc !== 32'h00001234) begin miscompares++; $display("FAIL jr: got %b/%h want 1/00001234", o_change_pc, o_pc); end
    idle(); ce = 1; jal = 1; op = 6'h03; pc = 32'h00400010; jal_addr = 26'h0100000; flush = 1;
    tick();
    vectors++; if (o_change_pc !== 1'b0 || o_ce !== 1'b0) begin miscompares++; $display("FAIL jal_flush: got %b/%b want 0/0", o_change_pc, o_ce); end
    idle(); tick();
  endtask

  task automatic test_reset_mid_mul();
    logic c, b; logic [31:0] v, hi, lo; int s;
    idle(); ce = 1; fn = 6'h11; rs = 32'hAAAA5555; tick();
    idle(); ce = 1; fn = 6'h13; rs = 32'h5555AAAA; tick();
    md_issue(6'h18, 32'd3, 32'd5, c, v, b);
    tick(); tick();
    ce = 1; fn = 6'h20; rs = 32'd1; rt = 32'd2;
    tick();
    vectors++; if (o_ce !== 1'b1 || o_value !== 32'd3 || o_busy !== 1'b1) begin miscompares++; $display("FAIL pre_reset: got ce=%b val=%h busy=%b want 1/3/1", o_ce, o_value, o_busy); end
    rst_n = 0;
    #1;
    vectors++; if (o_busy !== 1'b0 || o_ce !== 1'b0 || o_value !== 32'h0) begin miscompares++; $display("FAIL async_reset: got busy=%b ce=%b val=%h want 0/0/0", o_busy, o_ce, o_value); end
    idle();
    tick();
    rst_n = 1;
    tick();
    read_hilo(hi, lo, s);
    vectors++; if (hi !== 32'h0 || lo !== 32'h0 || s !== 0) begin miscompares++; $display("FAIL reset_hilo: got hi=%h lo=%h stalls=%0d want 0/0/0", hi, lo, s); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_flush_stall_mul();
    test_stall_hold();
    test_jump();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
